// File: rtl/bram_req_adapter.sv
// -----------------------------------------------------------------------------
// bram_req_adapter
//
// Initiator-side controller for one port of a block RAM with 1-cycle read
// latency. Turns a valid/ready request channel (reads and writes) into raw RAM
// port strobes. It returns read data on a valid/ready response channel. A
// 2-entry response FIFO, together with a credit rule, means read data coming
// out of the RAM is never lost when the response side stalls.
//
// Optional feature (compile-time macro BRAM_REQ_ADAPTER_WACK_EN):
//   When defined, every accepted write also produces one response beat
//   (rsp_is_write=1, rsp_data=0). That beat stays in order with read beats
//   and uses credit in the same way. When undefined, writes produce no
//   response and rsp_is_write is tied to 0.
//
// Parameters:
//   ADDR_WIDTH   RAM word address width
//   DATA_WIDTH   RAM word width
//
// Ports:
//   clock         single clock, all state on posedge
//   reset         asynchronous, active-high reset
//   req_valid     request present
//   req_ready     request accepted when req_valid & req_ready
//   req_write     1 = write, 0 = read
//   req_addr      word address
//   req_data      write data
//   rsp_valid     response present
//   rsp_ready     response consumed when rsp_valid & rsp_ready
//   rsp_data      read data (0 for write acknowledges)
//   rsp_is_write  response belongs to a write (0 unless the option is enabled)
//   mem_rd_addr   RAM read address
//   mem_re        RAM read enable
//   mem_wr_addr   RAM write address
//   mem_we        RAM write enable
//   mem_di        RAM write data
//   mem_do        RAM read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module bram_req_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_is_write,

  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // pend: a beat is arriving this cycle (read data on mem_do, or a write ack).
  logic                  pend;
  // cnt: FIFO occupancy, 0..2.
  logic [1:0]            cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_data [2];

`ifdef BRAM_REQ_ADAPTER_WACK_EN
  // Records whether the pending beat is a write ack. Each FIFO entry also
  // carries this flag.
  logic                  pend_write;
  logic                  fifo_flag [2];
`endif

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                  accept;
  logic                  head_valid;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit_used;
  logic [1:0]            cnt_next;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_flag;

  // Credit is computed from registered state only. This keeps rsp_ready off
  // the req_ready path. Every outstanding beat holds one credit, whether it
  // is still in flight (pend) or already buffered (cnt).
  assign credit_used = {1'b0, cnt} + {2'b00, pend};
  assign req_ready   = ~reset & (credit_used < 3'd2);
  assign accept      = req_valid & req_ready;

  // RAM strobes are driven straight from the accepted request. At most one
  // request is issued per cycle, so a read/write collision on this port
  // cannot happen.
  assign mem_re      = accept & ~req_write;
  assign mem_rd_addr = req_addr;
  assign mem_we      = accept & req_write;
  assign mem_wr_addr = req_addr;
  assign mem_di      = req_data;

  // Value of the beat that arrives this cycle when pend is set.
`ifdef BRAM_REQ_ADAPTER_WACK_EN
  assign beat_data = pend_write ? '0 : mem_do;
  assign beat_flag = pend_write;
`else
  assign beat_data = mem_do;
  assign beat_flag = 1'b0;
`endif

  assign head_valid = (cnt != 2'd0);

  // The oldest beat is always the FIFO head. Only when the FIFO is empty can
  // the arriving beat bypass straight to the response port.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rsp_data     = beat_data;
    rsp_is_write = beat_flag;
    if (head_valid) begin
      rsp_data = fifo_data[rd_ptr];
`ifdef BRAM_REQ_ADAPTER_WACK_EN
      rsp_is_write = fifo_flag[rd_ptr];
`else
      rsp_is_write = 1'b0;
`endif
    end
  end

  assign rsp_valid = ~reset & (head_valid | pend);

  // The arriving beat must be captured unless it bypasses and is consumed in
  // this same cycle. The RAM does not hold mem_do past this cycle.
  assign push = pend & (head_valid | ~rsp_ready);
  assign pop  = head_valid & rsp_ready;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 2'd1;
      2'b01:   cnt_next = cnt - 2'd1;
      default: cnt_next = cnt;  // idle, or push and pop together
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend   <= 1'b0;
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
`ifdef BRAM_REQ_ADAPTER_WACK_EN
      pend_write <= 1'b0;
`endif
    end else begin
`ifdef BRAM_REQ_ADAPTER_WACK_EN
      pend       <= accept;
      pend_write <= accept & req_write;
`else
      pend       <= accept & ~req_write;
`endif
      cnt <= cnt_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array is deliberately left without reset. Reset clears
  // cnt and the pointers, so stale entries can never be read, and the array
  // can map to plain registers or LUT RAM with no reset network.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= beat_data;
`ifdef BRAM_REQ_ADAPTER_WACK_EN
      fifo_flag[wr_ptr] <= beat_flag;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // The credit rule must keep the 2-entry FIFO from ever overflowing.
  fifo_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
      !(push && !pop && (cnt == 2'd2))
  ) else $error("bram_req_adapter: response FIFO overflow");

  cnt_in_range: assert property (
    @(posedge clock) disable iff (reset)
      cnt <= 2'd2
  ) else $error("bram_req_adapter: FIFO occupancy out of range");
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bram_req_adapter.
// The bench models a 1-cycle-latency RAM and drives it from the DUT's mem_*
// strobes. The reference model is a queue of expected response beats plus a
// shadow copy of memory contents. The number of outstanding beats gives the
// expected req_ready and rsp_valid. A cycle table covers backpressure, hand
// sequences cover the corner cases, and a random run closes out the test.
// -----------------------------------------------------------------------------
module tb_bram_req_adapter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_is_write;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_re;
  logic [AW-1:0] mem_wr_addr;
  logic          mem_we;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do;

  bram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_is_write (rsp_is_write),
    .mem_rd_addr  (mem_rd_addr),
    .mem_re       (mem_re),
    .mem_wr_addr  (mem_wr_addr),
    .mem_we       (mem_we),
    .mem_di       (mem_di),
    .mem_do       (mem_do)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM model: synchronous write, registered read (read-before-write).
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [1024];

  always @(posedge clock) begin
    if (pre_en)      ram[pre_addr]    <= pre_data;
    else if (mem_we) ram[mem_wr_addr] <= mem_di;
    if (mem_re)      mem_do <= ram[mem_rd_addr];
  end

  // Reference model.
  typedef struct {
    logic          flag;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q [$];
  logic [DW-1:0] shadow [1024];

  int n_checks = 0;
  int n_errors = 0;

  task automatic count(input string name, input logic ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %s expected %s at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    count(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic chk_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    count(name, act === exp, $sformatf("0x%0h", act), $sformatf("0x%0h", exp));
  endtask

  task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    count(name, act === exp, $sformatf("0x%0h", act), $sformatf("0x%0h", exp));
  endtask

  // Called at the negedge. Compares outputs against the model, waits for the
  // posedge, updates the model, and returns #1 after the edge so the caller
  // can drive the next cycle's inputs.
  task automatic sample_and_advance();
    logic  exp_ready;
    logic  exp_valid;
    logic  acc;
    logic  con;
    beat_t b;
    exp_ready = (exp_q.size() < 2);
    exp_valid = (exp_q.size() != 0);
    chk_bit("req_ready", req_ready, exp_ready);
    chk_bit("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      chk_word("rsp_data", rsp_data, exp_q[0].data);
      chk_bit("rsp_is_write", rsp_is_write, exp_q[0].flag);
    end
    acc = req_valid & exp_ready;
    con = rsp_ready & exp_valid;
    chk_bit("mem_re", mem_re, acc & ~req_write);
    chk_bit("mem_we", mem_we, acc & req_write);
    if (acc && !req_write) chk_addr("mem_rd_addr", mem_rd_addr, req_addr);
    if (acc && req_write) begin
      chk_addr("mem_wr_addr", mem_wr_addr, req_addr);
      chk_word("mem_di", mem_di, req_data);
    end
    @(posedge clock);
    if (con) b = exp_q.pop_front();
    if (acc) begin
      if (req_write) begin
        shadow[req_addr] = req_data;
`ifdef BRAM_REQ_ADAPTER_WACK_EN
        b.flag = 1'b1;
        b.data = '0;
        exp_q.push_back(b);
`endif
      end else begin
        b.flag = 1'b0;
        b.data = shadow[req_addr];
        exp_q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clock);
    sample_and_advance();
  endtask

  task automatic drive(input logic rv, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    req_valid = rv;
    req_write = rw;
    req_addr  = a;
    req_data  = d;
    rsp_ready = rr;
  endtask

  // Cycle table: inputs plus expected req_ready / rsp_valid / rsp_data.
  typedef struct {
    logic          rv;
    logic          rw;
    logic [AW-1:0] addr;
    logic          rr;
    logic          e_ready;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [AW-1:0] a, input logic rr,
                              input logic er, input logic ev, input logic [DW-1:0] ed);
    vec_t v;
    v.rv = rv; v.rw = 1'b0; v.addr = a; v.rr = rr;
    v.e_ready = er; v.e_valid = ev; v.e_data = ed;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    // Backpressure: reads of 1,2,3 (preloaded 3,6,9) against a stalled consumer.
    tbl[0] = mk(1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 32'd0);
    tbl[1] = mk(1'b1, 10'd2, 1'b0, 1'b1, 1'b1, 32'd3);
    tbl[2] = mk(1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 32'd3);
    tbl[3] = mk(1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 32'd3);
    tbl[4] = mk(1'b1, 10'd3, 1'b1, 1'b0, 1'b1, 32'd3);
    tbl[5] = mk(1'b1, 10'd3, 1'b1, 1'b1, 1'b1, 32'd6);
    tbl[6] = mk(1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 32'd9);
    tbl[7] = mk(1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 32'd0);

    // Reset behaviour, with a request held valid so output gating is visible.
    reset  = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive(1'b1, 1'b0, 10'd0, 32'd0, 1'b1);
    #3;
    chk_bit("reset_req_ready", req_ready, 1'b0);
    chk_bit("reset_rsp_valid", rsp_valid, 1'b0);
    chk_bit("reset_mem_re", mem_re, 1'b0);
    req_write = 1'b1;
    #1;
    chk_bit("reset_mem_we", mem_we, 1'b0);

    // Preload words 0..15 with i*3 while reset holds the DUT idle.
    for (int i = 0; i < 16; i++) begin
      pre_addr  = AW'(i);
      pre_data  = DW'(i * 3);
      shadow[i] = DW'(i * 3);
      pre_en    = 1'b1;
      @(posedge clock);
      #1;
    end
    pre_en = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    reset = 1'b0;
    step();

    // Table-driven backpressure sequence.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rv, tbl[i].rw, tbl[i].addr, 32'd0, tbl[i].rr);
      @(negedge clock);
      chk_bit($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_ready);
      chk_bit($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk_word($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].e_data);
      sample_and_advance();
    end

    // Streaming: eight back-to-back reads, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, AW'(i), 32'd0, 1'b1);
      @(negedge clock);
      chk_bit("stream_req_ready", req_ready, 1'b1);
      sample_and_advance();
    end
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    step();
    step();

    // Write then read the same address on consecutive cycles.
    drive(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b1);
    @(negedge clock);
    chk_bit("wr_mem_we", mem_we, 1'b1);
    sample_and_advance();
    drive(1'b1, 1'b0, 10'h005, 32'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk_bit("wr_rd_valid", rsp_valid, 1'b1);
    chk_word("wr_rd_data", rsp_data, 32'hDEADBEEF);
    sample_and_advance();
    step();

    // Simultaneous push/pop: build cnt=1,pend=1, then release the consumer.
    drive(1'b1, 1'b0, 10'd7, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 10'd8, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    step();
    step();
    step();

    // Reset with two beats outstanding.
    drive(1'b1, 1'b0, 10'd10, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 10'd11, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 10'd12, 32'd0, 1'b0);
    reset = 1'b1;
    #2;
    chk_bit("midrst_rsp_valid", rsp_valid, 1'b0);
    chk_bit("midrst_req_ready", req_ready, 1'b0);
    chk_bit("midrst_mem_re", mem_re, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_bit("postrst_req_ready", req_ready, 1'b1);
    chk_bit("postrst_rsp_valid", rsp_valid, 1'b0);
    step();
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
            AW'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 9) < 7));
      step();
    end
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
